// File: rtl/dp_mem_responder_pkg.sv
// Shared types for the datapath memory responder: word type, FSM states and
// the request record latched when an access is accepted.
package dp_mem_responder_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DACC   = 2'd1,
      IACC   = 2'd2,
      HALTED = 2'd3
   } resp_state_t;

   typedef struct packed {
      word_t addr;
      word_t store;
      logic  write;
   } req_t;

   localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/dp_mem_responder_if.sv
// Datapath-side request/response signals and RAM-side handshake bundled together.
// The slave view belongs to the responder; the master view to the datapath and RAM model.
interface dp_mem_responder_if;
   import dp_mem_responder_pkg::*;

   logic  imemREN;
   word_t imemaddr;
   logic  dmemREN;
   logic  dmemWEN;
   word_t dmemaddr;
   word_t dmemstore;
   logic  halt;
   logic  ihit;
   word_t imemload;
   logic  dhit;
   word_t dmemload;
   logic  ramREN;
   logic  ramWEN;
   word_t ramaddr;
   word_t ramstore;
   word_t ramload;
   logic  ram_ready;
   logic  done;
   logic  error;

   modport slave (
      input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
      input  ramload, ram_ready,
      output ihit, imemload, dhit, dmemload,
      output ramREN, ramWEN, ramaddr, ramstore, done, error
   );

   modport master (
      output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
      output ramload, ram_ready,
      input  ihit, imemload, dhit, dmemload,
      input  ramREN, ramWEN, ramaddr, ramstore, done, error
   );

endinterface

// File: rtl/dp_mem_responder.sv
// Arbitrates datapath instruction/data requests onto a single-ported RAM,
// data first, returning registered one-cycle hit pulses and a sticky timeout flag.
module dp_mem_responder
   import dp_mem_responder_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic CLK,
   input  logic nRST,
   dp_mem_responder_if.slave bus
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

   resp_state_t   state_reg, state_next;
   req_t          req_reg, req_next;
   logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
   logic [CW-1:0] wait_cnt_inc;
   logic          ihit_reg, ihit_next;
   logic          dhit_reg, dhit_next;
   word_t         imemload_reg, imemload_next;
   word_t         dmemload_reg, dmemload_next;
   logic          error_reg, error_next;
   logic          hit_cycle;
   logic          accessing;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg    <= IDLE;
         req_reg      <= '0;
         wait_cnt_reg <= '0;
         ihit_reg     <= 1'b0;
         dhit_reg     <= 1'b0;
         imemload_reg <= '0;
         dmemload_reg <= '0;
         error_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         req_reg      <= req_next;
         wait_cnt_reg <= wait_cnt_next;
         ihit_reg     <= ihit_next;
         dhit_reg     <= dhit_next;
         imemload_reg <= imemload_next;
         dmemload_reg <= dmemload_next;
         error_reg    <= error_next;
      end
   end

   // A hit cycle still sees the served request on the inputs; skip arbitration then.
   assign hit_cycle    = ihit_reg | dhit_reg;
   assign wait_cnt_inc = wait_cnt_reg + 1'b1;

   always_comb begin
      state_next    = state_reg;
      req_next      = req_reg;
      wait_cnt_next = wait_cnt_reg;
      ihit_next     = 1'b0;
      dhit_next     = 1'b0;
      imemload_next = imemload_reg;
      dmemload_next = dmemload_reg;
      error_next    = error_reg;

      case (state_reg)
         IDLE: begin
            if (!hit_cycle) begin
               if (bus.halt) begin
                  state_next = HALTED;
               end else if (bus.dmemREN || bus.dmemWEN) begin
                  state_next    = DACC;
                  req_next      = '{addr: bus.dmemaddr, store: bus.dmemstore, write: bus.dmemWEN};
                  wait_cnt_next = '0;
               end else if (bus.imemREN) begin
                  state_next    = IACC;
                  req_next      = '{addr: bus.imemaddr, store: '0, write: 1'b0};
                  wait_cnt_next = '0;
               end
            end
         end

         DACC, IACC: begin
            if (bus.ram_ready) begin
               state_next    = IDLE;
               wait_cnt_next = '0;
               if (state_reg == IACC) begin
                  ihit_next     = 1'b1;
                  imemload_next = bus.ramload;
               end else begin
                  dhit_next = 1'b1;
                  if (!req_reg.write) begin
                     dmemload_next = bus.ramload;
                  end
               end
            end else if (wait_cnt_reg != TIMEOUT_CNT) begin
               // Saturate at the limit; the access itself keeps waiting.
               wait_cnt_next = wait_cnt_inc;
               if (wait_cnt_inc == TIMEOUT_CNT) begin
                  error_next = 1'b1;
               end
            end
         end

         HALTED: begin
            state_next = HALTED;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign accessing = (state_reg == DACC) || (state_reg == IACC);

   assign bus.ramREN   = (state_reg == IACC) || ((state_reg == DACC) && !req_reg.write);
   assign bus.ramWEN   = (state_reg == DACC) && req_reg.write;
   assign bus.ramaddr  = accessing ? req_reg.addr : '0;
   assign bus.ramstore = ((state_reg == DACC) && req_reg.write) ? req_reg.store : '0;

   assign bus.ihit     = ihit_reg;
   assign bus.dhit     = dhit_reg;
   assign bus.imemload = imemload_reg;
   assign bus.dmemload = dmemload_reg;
   assign bus.done     = (state_reg == HALTED);
   assign bus.error    = error_reg;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Randomized bench for dp_mem_responder: the bench plays datapath and RAM, and
// predicts hits, latencies, load data and the timeout flag from a memory model.
module tb_dp_mem_responder;
   import dp_mem_responder_pkg::*;

   localparam int TMO = 4;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   dp_mem_responder_if bus();

   dp_mem_responder #(.TIMEOUT(TMO)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;
   int txn_id   = 0;

   always @(posedge CLK) cycle <= cycle + 1;

   // ram_mem is what the RAM model holds; ref_mem is what the datapath intended to store.
   word_t ram_mem [word_t];
   word_t ref_mem [word_t];
   bit    err_exp;
   word_t iload_exp;
   word_t dload_exp;

   function automatic word_t init_word(input word_t a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic word_t ram_rd(input word_t a);
      return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
   endfunction

   function automatic word_t ref_rd(input word_t a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic check(input string tag, input word_t got, input word_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.imemREN   = 1'b0;
      bus.imemaddr  = '0;
      bus.dmemREN   = 1'b0;
      bus.dmemWEN   = 1'b0;
      bus.dmemaddr  = '0;
      bus.dmemstore = '0;
      bus.halt      = 1'b0;
      bus.ramload   = '0;
      bus.ram_ready = 1'b0;
   endtask

   function automatic word_t out_flags();
      return 32'({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.done, bus.error});
   endfunction

   task automatic apply_reset();
      idle_inputs();
      nRST = 1'b0;
      repeat (2) @(negedge CLK);
      check("reset_flags", out_flags(), 32'd0);
      check("reset_words", bus.ramaddr | bus.ramstore | bus.imemload | bus.dmemload, 32'd0);
      nRST = 1'b1;
      @(negedge CLK);
      err_exp   = 1'b0;
      iload_exp = '0;
      dload_exp = '0;
   endtask

   // Acts as the RAM for one access: waits for a strobe, holds ram_ready low for
   // 'stall' cycles, then completes. Returns at the negedge where the hit is visible.
   task automatic serve(input string tag, input bit exp_w, input word_t exp_addr,
                        input word_t exp_store, input int stall, input bit scr_d, input bit scr_i);
      bit seen;
      int bad;
      int err_k;
      int exp_k;
      bit err_before;
      seen = 1'b0;
      bad = 0;
      err_k = -1;
      err_before = err_exp;
      for (int t = 0; t < 16; t++) begin
         if (bus.ramREN || bus.ramWEN) begin
            seen = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      check({tag, "_start"}, 32'(seen), 32'd1);
      if (!seen) return;
      for (int k = 0; k <= stall; k++) begin
         if (bus.ramREN !== !exp_w || bus.ramWEN !== exp_w || bus.ramaddr !== exp_addr ||
             (exp_w && bus.ramstore !== exp_store))
            bad++;
         if (!err_before && bus.error && err_k < 0) err_k = k;
         bus.ram_ready = (k == stall);
         bus.ramload   = (k == stall) ? ram_rd(bus.ramaddr) : $urandom;
         if (k == stall && bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
         if (scr_d) begin
            bus.dmemaddr  = $urandom;
            bus.dmemstore = $urandom;
         end
         if (scr_i) bus.imemaddr = $urandom;
         @(negedge CLK);
      end
      bus.ram_ready = 1'b0;
      bus.ramload   = $urandom;
      exp_k = (!err_before && stall >= TMO) ? TMO : -1;
      check({tag, "_ram_side"}, 32'(bad), 32'd0);
      check({tag, "_tmo_cycle"}, 32'(err_k), 32'(exp_k));
      if (stall >= TMO) err_exp = 1'b1;
   endtask

   // kind: 0 fetch, 1 load, 2 store, 3 store with dmemREN also set
   task automatic do_access(input int kind, input word_t addr, input word_t data,
                            input int stall, input bit hold_extra);
      int    t0;
      bit    is_d;
      bit    is_w;
      string tag;
      is_d = (kind != 0);
      is_w = (kind >= 2);
      tag  = (kind == 0) ? "fetch" : (kind == 1) ? "load" : "store";
      if (!is_d) begin
         bus.imemREN  = 1'b1;
         bus.imemaddr = addr;
      end else begin
         bus.dmemREN   = (kind != 2);
         bus.dmemWEN   = is_w;
         bus.dmemaddr  = addr;
         bus.dmemstore = data;
      end
      t0 = cycle;
      @(negedge CLK);
      serve(tag, is_w, addr, data, stall, is_d && !hold_extra, !is_d && !hold_extra);
      if (kind == 0) iload_exp = ref_rd(addr);
      else if (!is_w) dload_exp = ref_rd(addr);
      else ref_mem[addr] = data;
      check({tag, "_latency"}, 32'(cycle - t0 + 1), 32'(3 + stall));
      check({tag, "_hits"}, 32'({bus.ihit, bus.dhit}), is_d ? 32'd1 : 32'd2);
      check({tag, "_imemload"}, bus.imemload, iload_exp);
      check({tag, "_dmemload"}, bus.dmemload, dload_exp);
      check({tag, "_error"}, 32'(bus.error), 32'(err_exp));
      if (hold_extra) begin
         @(negedge CLK);
         check({tag, "_held_quiet"}, 32'({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN}), 32'd0);
      end
      bus.imemREN = 1'b0;
      bus.dmemREN = 1'b0;
      bus.dmemWEN = 1'b0;
      @(negedge CLK);
      check({tag, "_after"}, 32'({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN}), 32'd0);
      $display("txn %0d: %s addr=%h data=%h stall=%0d", txn_id, tag, addr, data, stall);
      txn_id++;
   endtask

   task automatic do_contention(input word_t daddr, input word_t iaddr, input int sd, input int si);
      int t0;
      bus.dmemREN  = 1'b1;
      bus.dmemaddr = daddr;
      bus.imemREN  = 1'b1;
      bus.imemaddr = iaddr;
      t0 = cycle;
      @(negedge CLK);
      serve("cont_d", 1'b0, daddr, '0, sd, 1'b1, 1'b0);
      dload_exp = ref_rd(daddr);
      check("cont_d_hits", 32'({bus.ihit, bus.dhit}), 32'd1);
      check("cont_d_latency", 32'(cycle - t0 + 1), 32'(3 + sd));
      check("cont_d_load", bus.dmemload, dload_exp);
      bus.dmemREN = 1'b0;
      @(negedge CLK);
      check("cont_gap", 32'({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN}), 32'd0);
      serve("cont_i", 1'b0, iaddr, '0, si, 1'b0, 1'b0);
      iload_exp = ref_rd(iaddr);
      check("cont_i_hits", 32'({bus.ihit, bus.dhit}), 32'd2);
      check("cont_i_latency", 32'(cycle - t0 + 1), 32'(6 + sd + si));
      check("cont_i_load", bus.imemload, iload_exp);
      check("cont_error", 32'(bus.error), 32'(err_exp));
      bus.imemREN = 1'b0;
      @(negedge CLK);
      check("cont_after", 32'({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN}), 32'd0);
      $display("txn %0d: contention daddr=%h iaddr=%h stalls=%0d/%0d", txn_id, daddr, iaddr, sd, si);
      txn_id++;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    kind;
      int    quiet;
      word_t a;
      word_t a2;

      ram_mem[32'h40] = 32'h8C22_0004;
      ref_mem[32'h40] = 32'h8C22_0004;
      apply_reset();

      do_access(0, 32'h40, '0, 0, 1'b0);
      do_access(0, 32'h40, '0, 0, 1'b1);
      do_contention(32'h100, 32'h40, 1, 2);
      do_access(0, 32'h80, '0, 3, 1'b0);
      do_access(1, 32'h300, '0, 8, 1'b0);
      do_access(2, 32'h200, 32'hDEAD_BEEF, 5, 1'b0);
      do_access(1, 32'h200, '0, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 4);
         a    = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         a2   = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         if (kind == 4) do_contention(a, a2, $urandom_range(0, 5), $urandom_range(0, 5));
         else do_access(kind, a, $urandom, $urandom_range(0, 5), 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            bus.ram_ready = 1'b1;
            @(negedge CLK);
            bus.ram_ready = 1'b0;
            check("stray_ready", 32'({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN}), 32'd0);
         end
      end

      // Halt raised while a load is in flight.
      apply_reset();
      bus.dmemREN  = 1'b1;
      bus.dmemaddr = 32'h1004;
      @(negedge CLK);
      bus.halt = 1'b1;
      serve("halt_ld", 1'b0, 32'h1004, '0, 2, 1'b0, 1'b0);
      dload_exp = ref_rd(32'h1004);
      check("halt_ld_hits", 32'({bus.ihit, bus.dhit, bus.done}), 32'd2);
      check("halt_ld_load", bus.dmemload, dload_exp);
      bus.dmemREN = 1'b0;
      @(negedge CLK);
      check("halt_not_yet", 32'(bus.done), 32'd0);
      @(negedge CLK);
      check("halt_done", 32'(bus.done), 32'd1);
      quiet = 0;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h40;
      for (int c = 0; c < 6; c++) begin
         bus.ram_ready = c[0];
         @(negedge CLK);
         if (bus.ramREN || bus.ramWEN || bus.ihit || bus.dhit || !bus.done) quiet++;
      end
      bus.ram_ready = 1'b0;
      bus.imemREN   = 1'b0;
      check("halt_quiet", 32'(quiet), 32'd0);
      $display("txn %0d: halt during load", txn_id);
      txn_id++;

      // Reset pulled in the middle of a fetch.
      apply_reset();
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h40;
      @(negedge CLK);
      check("rst_mid_strobe", 32'(bus.ramREN), 32'd1);
      #2;
      nRST = 1'b0;
      #1;
      check("rst_mid_flags", out_flags(), 32'd0);
      check("rst_mid_addr", bus.ramaddr, 32'd0);
      bus.imemREN   = 1'b0;
      bus.ram_ready = 1'b1;
      @(negedge CLK);
      bus.ram_ready = 1'b0;
      nRST = 1'b1;
      quiet = 0;
      repeat (3) begin
         @(negedge CLK);
         if (bus.ihit || bus.dhit || bus.ramREN || bus.ramWEN) quiet++;
      end
      check("rst_mid_no_hit", 32'(quiet), 32'd0);
      $display("txn %0d: reset during fetch", txn_id);
      txn_id++;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
